rally_physics_core: RTL and testbench

//  Parametrised fixed-point ball integrator plus rally/score sequencer for the 2-player volley game.

---
 rtl/rally_physics_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_rally_physics_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rally_physics_core.sv
// ---------------------------------------------------------------------------
// rally_physics_core
//   Fixed-point ball integrator and rally/score sequencer for the two-player
//   volley game. On each frame tick (en) the ball is advanced, contacts with
//   floor, net, walls and ceiling are resolved, hit commands are applied, and
//   the IDLE -> SERVE -> PLAY -> MATCH_END sequence keeps score.
//
//   Optional feature: define FRICTION_EN to bleed |vx| by FRICTION per tick
//   while |vx| > FRIC_SPEED (PLAY only). Default build has no friction.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en                  frame tick, 1-cycle pulse
//   start               start a new match (sampled on en)
//   hit_valid/vx/vy     hit command from hitbox logic (signed, scaled)
//   hit_ack             pulse: hit command consumed on this tick
//   ball_pos_x/y        ball position in whole pixels
//   ball_vx/vy          ball velocity, scaled
//   state               0 IDLE, 1 SERVE, 2 PLAY, 3 MATCH_END
//   score_p1/p2         points per player
//   point_valid         pulse when a point is scored
//   point_winner        0 = P1, 1 = P2; held until the next point
//   valid               pulse the cycle after every processed tick
// ---------------------------------------------------------------------------
module rally_physics_core #(
  parameter int FRAC       = 6,
  parameter int W          = 20,
  parameter int SCREEN_W   = 640,
  parameter int FLOOR_Y    = 480,
  parameter int BALL_SIZE  = 80,
  parameter int NET_X      = 320,
  parameter int NET_HW     = 3,
  parameter int NET_H      = 180,
  parameter int GRAVITY    = 25,
  parameter int VMAX       = 1000,
  parameter int SERVE_XL   = 120,
  parameter int SERVE_XR   = 440,
  parameter int SERVE_Y    = 50,
  parameter int SERVE_HOLD = 60,
  parameter int WIN_SCORE  = 7,
  parameter int FRICTION   = 3,
  parameter int FRIC_SPEED = 400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic                hit_valid,
  input  logic signed [W-1:0] hit_vx,
  input  logic signed [W-1:0] hit_vy,
  output logic                hit_ack,
  output logic [9:0]          ball_pos_x,
  output logic [9:0]          ball_pos_y,
  output logic signed [W-1:0] ball_vx,
  output logic signed [W-1:0] ball_vy,
  output logic [1:0]          state,
  output logic [3:0]          score_p1,
  output logic [3:0]          score_p2,
  output logic                point_valid,
  output logic                point_winner,
  output logic                valid
);

`ifdef FRICTION_EN
  localparam bit FRIC_ON = 1'b1;
`else
  localparam bit FRIC_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_MATCH_END = 2'd3} state_t;

  localparam int HOLD_W = $clog2(SERVE_HOLD + 1);

  // Geometry in scaled units (pixels << FRAC)
  localparam logic signed [W-1:0] FLOOR_LIM = W'((FLOOR_Y - BALL_SIZE) << FRAC);
  localparam logic signed [W-1:0] NET_L     = W'((NET_X - NET_HW) << FRAC);
  localparam logic signed [W-1:0] NET_R     = W'((NET_X + NET_HW) << FRAC);
  localparam logic signed [W-1:0] NET_TOP   = W'((FLOOR_Y - NET_H) << FRAC);
  localparam logic signed [W-1:0] NET_C     = W'(NET_X << FRAC);
  localparam logic signed [W-1:0] BALL_S    = W'(BALL_SIZE << FRAC);
  localparam logic signed [W-1:0] HALF_S    = W'((BALL_SIZE / 2) << FRAC);
  localparam logic signed [W-1:0] RWALL     = W'((SCREEN_W - BALL_SIZE) << FRAC);
  localparam logic signed [W-1:0] ONE_PX    = W'(1 << FRAC);
  localparam logic signed [W-1:0] XL_S      = W'(SERVE_XL << FRAC);
  localparam logic signed [W-1:0] XR_S      = W'(SERVE_XR << FRAC);
  localparam logic signed [W-1:0] Y_S       = W'(SERVE_Y << FRAC);
  localparam logic signed [W-1:0] VMAX_S    = W'(VMAX);
  localparam logic signed [W-1:0] FRIC_SPD  = W'(FRIC_SPEED);
  localparam logic signed [W-1:0] FRIC_DEC  = W'(FRICTION);
  localparam logic signed [W:0]   VMAX_E    = (W+1)'(VMAX);
  localparam logic signed [W:0]   GRAV_E    = (W+1)'(GRAVITY);

  // Saturation works on one extra bit so neither a raw hit value nor vy+g wraps.
  function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
    if (v > VMAX_E)       return VMAX_S;
    else if (v < -VMAX_E) return -VMAX_S;
    else                  return v[W-1:0];
  endfunction

  function automatic logic signed [W:0] sext(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic signed [W-1:0] mag(input logic signed [W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  state_t              st;
  logic                server;       // 0 = P1 serves, 1 = P2 serves
  logic [HOLD_W-1:0]   hold;
  logic signed [W-1:0] pos_x, pos_y, vx, vy;

  // Next-tick kinematics for PLAY
  logic signed [W-1:0] nvx, nvy, npx, npy;
  logic                floor_hit, floor_winner;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    floor_hit    = 1'b0;
    floor_winner = 1'b0;
    if (hit_valid) begin
      nvx = sat(sext(hit_vx));
      nvy = sat(sext(hit_vy));
    end else begin
      nvx = vx;
      nvy = sat(sext(vy) + GRAV_E);
    end
    if (FRIC_ON) begin
      if (nvx > FRIC_SPD)       nvx = nvx - FRIC_DEC;
      else if (nvx < -FRIC_SPD) nvx = nvx + FRIC_DEC;
    end
    // Position integrates the velocity held before this tick's update.
    npx = pos_x + vx;
    npy = pos_y + vy;

    if (npy >= FLOOR_LIM) begin
      floor_hit    = 1'b1;
      floor_winner = (npx + HALF_S < NET_C);  // landed on P1 side -> P2 scores
      npy          = FLOOR_LIM;
      nvx          = '0;
      nvy          = '0;
    end else if ((npx + BALL_S > NET_L) && (npx < NET_R) && (npy + BALL_S > NET_TOP)) begin
      if (npy + HALF_S < NET_TOP) begin
        npy = NET_TOP - BALL_S;               // resting on the net tape
        nvy = -mag(nvy);
      end else if (npx + HALF_S < NET_C) begin
        npx = NET_L - BALL_S - ONE_PX;        // knocked back to the left
        nvx = -mag(nvx);
      end else begin
        npx = NET_R + ONE_PX;                 // knocked back to the right
        nvx = mag(nvx);
      end
    end else begin
      if (npx < 0) begin
        npx = '0;
        nvx = mag(nvx);
      end else if (npx > RWALL) begin
        npx = RWALL;
        nvx = -mag(nvx);
      end
      if (npy < 0) begin
        npy = '0;
        nvy = mag(nvy);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      server       <= 1'b0;
      hold         <= '0;
      pos_x        <= XL_S;
      pos_y        <= Y_S;
      vx           <= '0;
      vy           <= '0;
      score_p1     <= '0;
      score_p2     <= '0;
      hit_ack      <= 1'b0;
      point_valid  <= 1'b0;
      point_winner <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid       <= en;
      hit_ack     <= 1'b0;
      point_valid <= 1'b0;
      if (en) begin
        unique case (st)
          S_IDLE, S_MATCH_END: begin
            if (start) begin
              st       <= S_SERVE;
              score_p1 <= '0;
              score_p2 <= '0;
              server   <= 1'b0;
              hold     <= HOLD_W'(SERVE_HOLD);
            end
          end
          S_SERVE: begin
            pos_x <= server ? XR_S : XL_S;
            pos_y <= Y_S;
            vx    <= '0;
            vy    <= '0;
            if (hold == '0) st <= S_PLAY;
            else            hold <= hold - HOLD_W'(1);
          end
          S_PLAY: begin
            hit_ack <= hit_valid;
            pos_x   <= npx;
            pos_y   <= npy;
            vx      <= nvx;
            vy      <= nvy;
            if (floor_hit) begin
              point_valid  <= 1'b1;
              point_winner <= floor_winner;
              server       <= ~floor_winner;      // loser serves next
              hold         <= HOLD_W'(SERVE_HOLD);
              st           <= S_SERVE;
              if (floor_winner) begin
                score_p2 <= score_p2 + 4'd1;
                if (score_p2 == 4'(WIN_SCORE - 1)) st <= S_MATCH_END;
              end else begin
                score_p1 <= score_p1 + 4'd1;
                if (score_p1 == 4'(WIN_SCORE - 1)) st <= S_MATCH_END;
              end
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign state      = st;
  assign ball_pos_x = 10'(pos_x >>> FRAC);
  assign ball_pos_y = 10'(pos_y >>> FRAC);
  assign ball_vx    = vx;
  assign ball_vy    = vy;

endmodule

// File: tb/tb_rally_physics_core.sv
// ---------------------------------------------------------------------------
// tb_rally_physics_core
//   Scoreboard bench for rally_physics_core. Each frame tick pushes its
//   hand-computed expectation; a monitor pops and compares on every valid.
// ---------------------------------------------------------------------------
module tb_rally_physics_core;

  localparam int M_ST  = 1;   // state + scores
  localparam int M_KIN = 2;   // position + velocity
  localparam int M_PUL = 4;   // hit_ack, point_valid, point_winner
  localparam int M_ALL = 7;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, MEND = 3;

  typedef struct {
    int mask;
    int px, py, vx, vy;
    int st, s1, s2;
    int hack, pv, pw;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0, start = 1'b0, hit_valid = 1'b0;
  logic signed [19:0] hit_vx = '0, hit_vy = '0;
  logic               hit_ack, point_valid, point_winner, valid;
  logic [9:0]         ball_pos_x, ball_pos_y;
  logic signed [19:0] ball_vx, ball_vy;
  logic [1:0]         state;
  logic [3:0]         score_p1, score_p2;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  rally_physics_core dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .hit_valid(hit_valid), .hit_vx(hit_vx), .hit_vy(hit_vy), .hit_ack(hit_ack),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .ball_vx(ball_vx), .ball_vy(ball_vy), .state(state),
    .score_p1(score_p1), .score_p2(score_p2),
    .point_valid(point_valid), .point_winner(point_winner), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic exp_t ex(input int mask, px, py, vx, vy, st, s1, s2, hack, pv, pw);
    exp_t e;
    e.mask = mask; e.px = px; e.py = py; e.vx = vx; e.vy = vy;
    e.st = st; e.s1 = s1; e.s2 = s2; e.hack = hack; e.pv = pv; e.pw = pw;
    return e;
  endfunction

  function automatic exp_t exs(input int st, s1, s2);
    return ex(M_ST, 0, 0, 0, 0, st, s1, s2, 0, 0, 0);
  endfunction

  task automatic compare(input string nm, input exp_t e);
    if ((e.mask & M_ST) != 0) begin
      check({nm, ".state"}, state, e.st);
      check({nm, ".score_p1"}, score_p1, e.s1);
      check({nm, ".score_p2"}, score_p2, e.s2);
    end
    if ((e.mask & M_KIN) != 0) begin
      check({nm, ".pos_x"}, ball_pos_x, e.px);
      check({nm, ".pos_y"}, ball_pos_y, e.py);
      check({nm, ".vx"}, ball_vx, e.vx);
      check({nm, ".vy"}, ball_vy, e.vy);
    end
    if ((e.mask & M_PUL) != 0) begin
      check({nm, ".hit_ack"}, hit_ack, e.hack);
      check({nm, ".point_valid"}, point_valid, e.pv);
      check({nm, ".point_winner"}, point_winner, e.pw);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, ".state"}, state, IDLE);
    check({nm, ".pos_x"}, ball_pos_x, 120);
    check({nm, ".pos_y"}, ball_pos_y, 50);
    check({nm, ".vx"}, ball_vx, 0);
    check({nm, ".vy"}, ball_vy, 0);
    check({nm, ".score_p1"}, score_p1, 0);
    check({nm, ".score_p2"}, score_p2, 0);
    check({nm, ".hit_ack"}, hit_ack, 0);
    check({nm, ".point_valid"}, point_valid, 0);
    check({nm, ".point_winner"}, point_winner, 0);
    check({nm, ".valid"}, valid, 0);
  endtask

  // One frame tick: queue the expectation, pulse en with the given inputs.
  task automatic tick(input string nm, input exp_t e, input logic st_in, input logic hv,
                      input int hx, input int hy);
    @(negedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    en = 1'b1; start = st_in; hit_valid = hv;
    hit_vx = 20'(hx); hit_vy = 20'(hy);
    @(negedge clk);
    en = 1'b0; start = 1'b0; hit_valid = 1'b0;
  endtask

  // Monitor: every valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no output");
      end else begin
        compare(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  initial begin
    // ---- reset and idle hold ----
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("no_en_hold.state", state, IDLE);
    check("no_en_hold.valid", valid, 0);
    start = 1'b0;

    // ---- start, serve hold, first PLAY tick, free fall on P1 side ----
    tick("start", ex(M_ALL, 120, 50, 0, 0, SERVE, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    tick("serve_hit_ignored", ex(M_ALL, 120, 50, 0, 0, SERVE, 0, 0, 0, 0, 0), 0, 1, 500, 500);
    for (int i = 2; i <= 60; i++) tick("serve_hold", exs(SERVE, 0, 0), 0, 0, 0, 0);
    tick("serve_to_play", ex(M_ST | M_KIN, 120, 50, 0, 0, PLAY, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    tick("first_play", ex(M_ALL, 120, 50, 0, 25, PLAY, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    for (int i = 2; i <= 42; i++) tick("free_fall", exs(PLAY, 0, 0), 0, 0, 0, 0);
    tick("floor_p2_point", ex(M_ALL, 120, 400, 0, 0, SERVE, 0, 1, 0, 1, 1), 0, 0, 0, 0);
    tick("loser_p1_serves", ex(M_ALL, 120, 50, 0, 0, SERVE, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    for (int i = 2; i <= 60; i++) tick("serve_hold2", exs(SERVE, 0, 1), 0, 0, 0, 0);
    tick("serve_to_play2", exs(PLAY, 0, 1), 0, 0, 0, 0);

    // ---- steered rally: net side, saturation, net top, ceiling, walls ----
    tick("hit_first", ex(M_ALL, 120, 50, 500, 1000, PLAY, 0, 1, 1, 0, 1), 0, 1, 500, 1000);
    for (int i = 2; i <= 14; i++) tick("steer_down", exs(PLAY, 0, 1), 0, 1, 500, 1000);
    tick("hit_slow", ex(M_ALL, 229, 268, 400, 0, PLAY, 0, 1, 1, 0, 1), 0, 1, 400, 0);
    tick("gravity", ex(M_ALL, 235, 268, 400, 25, PLAY, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    tick("net_side", ex(M_ALL, 236, 269, -400, 50, PLAY, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    tick("hit_saturate", ex(M_ALL, 229, 269, 1000, -1000, PLAY, 0, 1, 1, 0, 1), 0, 1, 2000, -2000);
    tick("net_top", ex(M_ALL, 245, 220, 1000, -975, PLAY, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    tick("clear_net", ex(M_ALL, 261, 204, -1000, -1000, PLAY, 0, 1, 1, 0, 1), 0, 1, -1000, -1000);
    for (int i = 21; i <= 33; i++) tick("steer_up", exs(PLAY, 0, 1), 0, 1, -1000, -1000);
    tick("ceiling", ex(M_ALL, 42, 0, -1000, 1000, PLAY, 0, 1, 1, 0, 1), 0, 1, -1000, -1000);
    tick("steer_left", exs(PLAY, 0, 1), 0, 1, -1000, 0);
    tick("vx_kept", ex(M_ALL, 11, 15, -1000, 25, PLAY, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    tick("left_wall", ex(M_ALL, 0, 16, 1000, 50, PLAY, 0, 1, 0, 0, 1), 0, 0, 0, 0);
    for (int i = 38; i <= 72; i++) tick("steer_right", exs(PLAY, 0, 1), 0, 1, 1000, 0);
    tick("right_wall", ex(M_ALL, 560, 16, -1000, 0, PLAY, 0, 1, 1, 0, 1), 0, 1, 1000, 0);
    for (int i = 74; i <= 98; i++) tick("steer_floor", exs(PLAY, 0, 1), 0, 1, 0, 1000);
    tick("floor_with_hit", ex(M_ALL, 544, 400, 0, 0, SERVE, 1, 1, 1, 1, 0), 0, 1, 0, 1000);

    // ---- P2 serves repeatedly and loses each point until P1 reaches 7 ----
    for (int p = 2; p <= 7; p++) begin
      tick("p2_serve_pos", ex(M_ST | M_KIN, 440, 50, 0, 0, SERVE, p - 1, 1, 0, 0, 0), 0, 0, 0, 0);
      for (int i = 2; i <= 60; i++) tick("serve_hold_p2", exs(SERVE, p - 1, 1), 0, 0, 0, 0);
      tick("serve_to_play_p2", exs(PLAY, p - 1, 1), 0, 0, 0, 0);
      for (int i = 1; i <= 42; i++) tick("free_fall_p2", exs(PLAY, p - 1, 1), 0, 0, 0, 0);
      tick("floor_p1_point", ex(M_ALL, 440, 400, 0, 0, (p == 7) ? MEND : SERVE, p, 1, 0, 1, 0),
           0, 0, 0, 0);
    end

    // ---- match end, restart, reset mid-rally ----
    tick("match_end_frozen", ex(M_ALL, 440, 400, 0, 0, MEND, 7, 1, 0, 0, 0), 0, 1, 300, 300);
    tick("restart", ex(M_ALL, 440, 400, 0, 0, SERVE, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    tick("restart_serve_pos", ex(M_ST | M_KIN, 120, 50, 0, 0, SERVE, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    for (int i = 2; i <= 60; i++) tick("serve_hold3", exs(SERVE, 0, 0), 0, 0, 0, 0);
    tick("serve_to_play3", exs(PLAY, 0, 0), 0, 0, 0, 0);
    tick("play_after_restart", ex(M_ALL, 120, 50, 0, 25, PLAY, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; start = 1'b1; hit_valid = 1'b1;
    @(negedge clk);
    check_reset("reset_mid_play");
    rst = 1'b0; en = 1'b0; start = 1'b0; hit_valid = 1'b0;

    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_valid %s: got no output expected one", name_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
